// File: rtl/mult_booth_32_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package mult_booth_32_pkg;

    localparam int STEPS = 32;
    localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    // 66-bit product register {U, L, q}; U carries one guard bit above the 32-bit sum.
    typedef struct packed {
        logic [32:0] u;
        logic [31:0] l;
        logic        q;
    } acc_t;

endpackage

// File: rtl/mult_booth_32_if.sv
// Operand/strobe and result bundle between the operand latches and the multiplier.
interface mult_booth_32_if;

    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );

endinterface

// File: rtl/adder_32.sv
// 32-bit two's-complement adder with signed-overflow flag; shared add engine of the multdiv path.
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        ov
);

    assign sum = a + b;
    assign ov  = (a[31] == b[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/mult_booth_32_booth_step.sv
// One combinational radix-2 Booth iteration: select addend, add into U, shift {U, L, q} right.
module booth_step
    import mult_booth_32_pkg::*;
(
    input  acc_t        acc,
    input  logic [31:0] m,
    input  logic [31:0] neg_m,
    output acc_t        acc_next
);

    logic [31:0] b;
    logic        b32;
    logic [31:0] s;
    logic        ov;
    logic        c32;
    logic        s32;

    // NOTE: defaults come first so every path assigns b/b32 and no latch is inferred.
    always_comb begin
        b   = '0;
        b32 = 1'b0;
        unique case ({acc.l[0], acc.q})
            2'b01: begin
                b   = m;
                b32 = m[31];
            end
            2'b10: begin
                b   = neg_m;
                // -M as a 33-bit value: +2^31 for M=0x80000000, zero for M=0.
                b32 = ~m[31] & (m != '0);
            end
            default: ;
        endcase
    end

    adder_32 u_add (
        .a   (acc.u[31:0]),
        .b   (b),
        .sum (s),
        .ov  (ov)
    );

    // Recover the carry out of bit 31 from the overflow flag to extend the sum to 33 bits.
    assign c32 = s[31] ^ acc.u[31] ^ b[31] ^ ov;
    assign s32 = acc.u[32] ^ b32 ^ c32;

    assign acc_next.u = {s32, s32, s[31:1]};
    assign acc_next.l = {s[0], acc.l[31:1]};
    assign acc_next.q = acc.l[0];

endmodule

// File: rtl/mult_booth_32.sv
// Sequential 32x32 signed Booth multiplier: low product word, overflow flag, one-cycle ready pulse.
module mult_booth_32
    import mult_booth_32_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    mult_booth_32_if.slave   bus
);

    state_t      state;
    state_t      state_next;
    acc_t        acc;
    acc_t        step_next;
    logic [31:0] m;
    logic [31:0] neg_m;
    logic [31:0] neg_m_sum;
    logic        unused_neg_ov;
    logic [4:0]  count;
    logic [31:0] result;
    logic        exception;
    logic        rdy;
    logic        start;
    logic        last_step;

    assign start     = bus.ctrl_MULT;
    assign last_step = (state == RUN) && (count == LAST_STEP);

    adder_32 u_neg (
        .a   (~m),
        .b   (32'h1),
        .sum (neg_m_sum),
        .ov  (unused_neg_ov)
    );

    booth_step u_step (
        .acc      (acc),
        .m        (m),
        .neg_m    (neg_m),
        .acc_next (step_next)
    );

    // A start strobe preempts whatever operation is in flight.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = LOAD;
        end else begin
            unique case (state)
                IDLE:    state_next = IDLE;
                LOAD:    state_next = RUN;
                RUN:     state_next = (count == LAST_STEP) ? DONE : RUN;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            m         <= '0;
            neg_m     <= '0;
            count     <= '0;
            result    <= '0;
            exception <= 1'b0;
            rdy       <= 1'b0;
        end else begin
            state <= state_next;
            rdy   <= 1'b0;
            if (start) begin
                m     <= bus.data_operandA;
                acc   <= '{u: '0, l: bus.data_operandB, q: 1'b0};
                count <= '0;
            end else begin
                if (state == LOAD) begin
                    neg_m <= neg_m_sum;
                end
                if (state == RUN) begin
                    acc   <= step_next;
                    count <= count + 5'd1;
                end
                if (last_step) begin
                    result    <= step_next.l;
                    exception <= (step_next.u != {33{step_next.l[31]}});
                    rdy       <= 1'b1;
                end
            end
        end
    end

    assign bus.data_result    = result;
    assign bus.data_exception = exception;
    assign bus.data_resultRDY = rdy;

endmodule

// File: tb/tb_mult_booth_32.sv
// Scoreboard bench for mult_booth_32: directed corner products, random products, restart and reset abort.
module tb_mult_booth_32;

    typedef struct {
        logic [31:0] result;
        logic        exc;
        int          start;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   chk_low = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    mult_booth_32_if bus ();

    mult_booth_32 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int start);
        exp_t        e;
        longint      p;
        logic [63:0] pv;
        p  = longint'($signed(a)) * longint'($signed(b));
        pv = p;
        e.result = pv[31:0];
        e.exc    = (pv != {{32{pv[31]}}, pv[31:0]});
        e.start  = start;
        return e;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding start and last exactly one cycle.
    always @(negedge clock) begin
        if (chk_low) begin
            check("rdy_width", 64'(bus.data_resultRDY), 64'd0);
            chk_low = 1'b0;
        end else if (bus.data_resultRDY) begin
            if (sb.size() == 0) begin
                check("spurious_rdy", 64'(bus.data_resultRDY), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result", 64'(bus.data_result), 64'(mon_e.result));
                check("exception", 64'(bus.data_exception), 64'(mon_e.exc));
                check("latency", 64'(cyc - mon_e.start), 64'd33);
                chk_low = 1'b1;
            end
        end
    end

    // Called at a falling edge; the strobe is sampled at the following rising edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_done();
        int budget = 60;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (sb.size() != 0) begin
            check("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    logic [31:0] dir_a [9] = '{32'd7, 32'hFFFFFFFD, 32'd0, 32'h80000000, 32'h80000000,
                               32'h00010000, 32'hFFFF8000, 32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [31:0] dir_b [9] = '{32'd6, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'd1,
                               32'h00010000, 32'h00010000, 32'h7FFFFFFF, 32'hFFFFFFFF};

    initial begin
        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        #1;
        check("reset_result", 64'(bus.data_result), 64'd0);
        check("reset_exception", 64'(bus.data_exception), 64'd0);
        check("reset_rdy", 64'(bus.data_resultRDY), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 9; i++) begin
            start_op(dir_a[i], dir_b[i]);
            wait_done();
        end

        for (int i = 0; i < 6; i++) begin
            start_op($urandom, $urandom);
            wait_done();
        end

        // Restart coincident with DONE: the finished result still pulses, the new one runs.
        start_op(32'd9, 32'hFFFFFFFD);
        repeat (33) @(negedge clock);
        check("done_rdy", 64'(bus.data_resultRDY), 64'd1);
        start_op(32'hFFFFFFF0, 32'h00001234);
        wait_done();

        // Restart mid-RUN: the first operation is dropped and must never pulse.
        start_op(32'd3, 32'd4);
        repeat (11) @(negedge clock);
        void'(sb.pop_back());
        start_op(32'd5, 32'd5);
        wait_done();

        // Asynchronous reset during RUN clears outputs at once and abandons the operation.
        start_op(32'd100, 32'd200);
        repeat (16) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_result", 64'(bus.data_result), 64'd0);
        check("abort_exception", 64'(bus.data_exception), 64'd0);
        check("abort_rdy", 64'(bus.data_resultRDY), 64'd0);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        start_op(32'd2, 32'd2);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
